asic_function_sequencer: RTL and testbench

- Downstream consumer of the ASIC function interface register block. Takes its `ctrl` and `asic_data_out` words and runs one handshake transaction per start pulse with the external nonlinear-function ASIC.
- Each transaction: drive the input code, wait a settle time, run a 4-phase req/ack handshake, capture the ASIC result.
- Returns status and result as the 32-bit `asic_data_in` word that the register block samples every cycle.

---
 rtl/asic_function_sequencer.sv | 173 +++++++++++++++++
 tb/tb_asic_function_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/asic_function_sequencer.sv
// rtl/asic_function_sequencer.sv - req/ack handshake sequencer for the nonlinear-function ASIC
//
// Runs one transaction per accepted start pulse:
//   latch input code -> settle -> 4-phase req/ack -> capture result.
// Status and result are returned as a registered 32-bit word
// {busy, done, err, 13'b0, result[15:0]}.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   ctrl          [0] start pulse, [2] abort level, [15:8] settle, [31:16] timeout
//   asic_data_out input code word, low DATA_W bits used
//   asic_data_in  registered status/result word
//   asic_wdata    code driven to the ASIC, held between transactions
//   asic_req      handshake request
//   asic_ack      handshake acknowledge, asynchronous to clk
//   asic_rdata    ASIC result, stable while ack is high

module asic_function_sequencer #(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       ctrl,
   input  logic [31:0]       asic_data_out,
   output logic [31:0]       asic_data_in,
   output logic [DATA_W-1:0] asic_wdata,
   output logic              asic_req,
   input  logic              asic_ack,
   input  logic [DATA_W-1:0] asic_rdata
);

   typedef enum logic [1:0] {IDLE, SETTLE, REQ, RELEASE} state_t;

   state_t              state, state_n;
   logic [SYNC_STAGES-1:0] ack_sync;
   logic                ack_s;
   logic [7:0]          settle_cnt, settle_cnt_n;
   logic [15:0]         tmo_cnt, tmo_cnt_n;
   logic [15:0]         tmo_lim, tmo_lim_n;
   logic [15:0]         tmo_inc;
   logic [15:0]         result, result_n;
   logic [DATA_W-1:0]   wdata_n;
   logic                req_n;
   logic                done, done_n;
   logic                err, err_n;
   logic                busy;
   logic                start;
   logic                abort;
   logic                tmo_hit;
   logic                unused_inputs;

   assign start = ctrl[0];
   assign abort = ctrl[2];
   assign ack_s = ack_sync[SYNC_STAGES-1];
   assign busy  = (state != IDLE);

   // Saturating increment; the compare looks at the post-increment value so
   // that a limit of T drops req after exactly T cycles in the handshake.
   assign tmo_inc = (tmo_cnt == 16'hFFFF) ? tmo_cnt : tmo_cnt + 16'd1;
   assign tmo_hit = (tmo_lim != 16'd0) && (tmo_inc >= tmo_lim);

   assign unused_inputs = ^{ctrl[7:3], ctrl[1], asic_data_out[31:DATA_W]};

   always_comb begin
      state_n      = state;
      settle_cnt_n = settle_cnt;
      tmo_cnt_n    = tmo_cnt;
      tmo_lim_n    = tmo_lim;
      result_n     = result;
      wdata_n      = asic_wdata;
      req_n        = asic_req;
      done_n       = done;
      err_n        = err;

      case (state)
         IDLE: begin
            req_n = 1'b0;
            if (start && !abort) begin
               wdata_n = asic_data_out[DATA_W-1:0];
               done_n  = 1'b0;
               err_n   = 1'b0;
               if (ack_s) begin
                  // ASIC still acknowledging a previous request: refuse to start.
                  err_n  = 1'b1;
                  done_n = 1'b1;
               end else begin
                  settle_cnt_n = (ctrl[15:8] == 8'd0) ? 8'd1 : ctrl[15:8];
                  tmo_lim_n    = ctrl[31:16];
                  state_n      = SETTLE;
               end
            end
         end
         SETTLE: begin
            if (settle_cnt == 8'd0) begin
               state_n   = REQ;
               req_n     = 1'b1;
               tmo_cnt_n = 16'd0;
            end else begin
               settle_cnt_n = settle_cnt - 8'd1;
            end
         end
         REQ: begin
            tmo_cnt_n = tmo_inc;
            if (tmo_hit) begin
               req_n   = 1'b0;
               err_n   = 1'b1;
               done_n  = 1'b1;
               state_n = IDLE;
            end else if (ack_s) begin
               result_n = 16'(asic_rdata);
               req_n    = 1'b0;
               state_n  = RELEASE;
            end
         end
         RELEASE: begin
            tmo_cnt_n = tmo_inc;
            req_n     = 1'b0;
            if (tmo_hit) begin
               err_n   = 1'b1;
               done_n  = 1'b1;
               state_n = IDLE;
            end else if (!ack_s) begin
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
            req_n   = 1'b0;
         end
      endcase

      // Abort overrides everything else in an active transaction.
      if (abort && (state != IDLE)) begin
         state_n  = IDLE;
         req_n    = 1'b0;
         done_n   = 1'b0;
         err_n    = 1'b0;
         result_n = result;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         ack_sync     <= '0;
         settle_cnt   <= 8'd0;
         tmo_cnt      <= 16'd0;
         tmo_lim      <= 16'd0;
         result       <= 16'd0;
         asic_wdata   <= '0;
         asic_req     <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         asic_data_in <= 32'd0;
      end else begin
         state        <= state_n;
         ack_sync     <= {ack_sync[SYNC_STAGES-2:0], asic_ack};
         settle_cnt   <= settle_cnt_n;
         tmo_cnt      <= tmo_cnt_n;
         tmo_lim      <= tmo_lim_n;
         result       <= result_n;
         asic_wdata   <= wdata_n;
         asic_req     <= req_n;
         done         <= done_n;
         err          <= err_n;
         asic_data_in <= {busy, done, err, 13'd0, result};
      end
   end

endmodule

// File: tb/tb_asic_function_sequencer.sv
// tb/tb_asic_function_sequencer.sv - directed self-checking bench for asic_function_sequencer

module tb_asic_function_sequencer;

   logic        clk;
   logic        rst;
   logic [31:0] ctrl;
   logic [31:0] asic_data_out;
   logic [31:0] asic_data_in;
   logic [15:0] asic_wdata;
   logic        asic_req;
   logic        asic_ack;
   logic [15:0] asic_rdata;

   int vec_count   = 0;
   int miscompares = 0;

   // ASIC model controls
   logic        model_en    = 1'b1;
   logic        stuck       = 1'b0;
   int          ack_delay   = 3;
   logic [15:0] model_rdata = 16'h0000;
   int          wait_cnt    = 0;

   int  req_rises = 0;
   logic req_prev = 1'b0;

   asic_function_sequencer #(.DATA_W(16), .SYNC_STAGES(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .ctrl         (ctrl),
      .asic_data_out(asic_data_out),
      .asic_data_in (asic_data_in),
      .asic_wdata   (asic_wdata),
      .asic_req     (asic_req),
      .asic_ack     (asic_ack),
      .asic_rdata   (asic_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ASIC model: acks ack_delay cycles after seeing req, drops ack after req falls.
   initial begin
      asic_ack   = 1'b0;
      asic_rdata = 16'h0000;
      forever begin
         @(posedge clk);
         #1;
         if (stuck) begin
            asic_ack = 1'b1;
         end else if (!model_en) begin
            asic_ack = 1'b0;
            wait_cnt = 0;
         end else if (asic_req && !asic_ack) begin
            wait_cnt++;
            if (wait_cnt >= ack_delay) begin
               asic_rdata = model_rdata;
               asic_ack   = 1'b1;
               wait_cnt   = 0;
            end
         end else if (!asic_req && asic_ack) begin
            asic_ack = 1'b0;
         end else begin
            wait_cnt = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (asic_req && !req_prev) req_rises++;
      req_prev = asic_req;
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_count++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Returns at the negedge just after the start cycle.
   task automatic pulse_start(input logic [31:0] c);
      @(negedge clk);
      ctrl = c;
      @(negedge clk);
      ctrl = c & ~32'h1;
   endtask

   task automatic wait_req(input logic level, input int max, output int n);
      n = 0;
      while (asic_req !== level && n < max) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_done(input int max);
      int n;
      n = 0;
      while (!(asic_data_in[31] == 1'b0 && asic_data_in[30] == 1'b1) && n < max) begin
         @(negedge clk);
         n++;
      end
      check_vec("done_wait", 32'(n < max), 32'd1);
   endtask

   initial begin
      int n;
      int rises0;
      rst           = 1'b1;
      ctrl          = 32'd0;
      asic_data_out = 32'd0;

      // Reset then idle
      repeat (2) @(negedge clk);
      check_vec("rst_data_in", asic_data_in, 32'h0000_0000);
      check_vec("rst_req", 32'(asic_req), 32'd0);
      check_vec("rst_wdata", 32'(asic_wdata), 32'd0);
      rst = 1'b0;
      asic_data_out = 32'h0000_4321;
      pulse_start(32'h0000_0305);
      ctrl = 32'd0;
      repeat (3) @(negedge clk);
      check_vec("abort_start_data_in", asic_data_in, 32'h0000_0000);
      check_vec("abort_start_wdata", 32'(asic_wdata), 32'd0);
      check_vec("abort_start_rises", 32'(req_rises), 32'd0);

      // Nominal transaction
      asic_data_out = 32'h0000_1234;
      model_rdata   = 16'hBEEF;
      ack_delay     = 3;
      pulse_start(32'h0000_0501);
      check_vec("nom_wdata", 32'(asic_wdata), 32'h0000_1234);
      wait_req(1'b1, 50, n);
      check_vec("nom_req_latency", 32'(n), 32'd6);
      wait_done(100);
      check_vec("nom_data_in", asic_data_in, 32'h4000_BEEF);

      // Settle zero, re-pulse while busy
      repeat (4) @(negedge clk);
      rises0        = req_rises;
      asic_data_out = 32'h0000_0055;
      model_rdata   = 16'h0055;
      ack_delay     = 8;
      pulse_start(32'h0000_0001);
      wait_req(1'b1, 50, n);
      check_vec("s0_req_latency", 32'(n), 32'd2);
      pulse_start(32'h0000_0001);
      wait_done(100);
      check_vec("s0_data_in", asic_data_in, 32'h4000_0055);
      repeat (10) @(negedge clk);
      check_vec("s0_req_pulses", 32'(req_rises - rises0), 32'd1);
      check_vec("s0_idle_data_in", asic_data_in, 32'h4000_0055);

      // Timeout with no ack
      model_en = 1'b0;
      pulse_start(32'h000A_0101);
      wait_req(1'b1, 50, n);
      check_vec("tmo_req_latency", 32'(n), 32'd2);
      wait_req(1'b0, 50, n);
      check_vec("tmo_req_width", 32'(n), 32'd10);
      wait_done(100);
      check_vec("tmo_data_in", asic_data_in, 32'h6000_0055);
      model_en = 1'b1;

      // Stuck ack
      stuck = 1'b1;
      repeat (5) @(negedge clk);
      rises0        = req_rises;
      asic_data_out = 32'h0000_0777;
      pulse_start(32'h0000_0301);
      repeat (3) @(negedge clk);
      check_vec("stuck_flags", 32'(asic_data_in[31:29]), 32'd3);
      check_vec("stuck_data_in", asic_data_in, 32'h6000_0055);
      check_vec("stuck_wdata", 32'(asic_wdata), 32'h0000_0777);
      check_vec("stuck_no_req", 32'(req_rises - rises0), 32'd0);
      stuck = 1'b0;
      repeat (6) @(negedge clk);

      // Abort during REQ
      ack_delay   = 20;
      model_rdata = 16'hDEAD;
      pulse_start(32'h0000_0201);
      wait_req(1'b1, 50, n);
      check_vec("abt_req_latency", 32'(n), 32'd3);
      ctrl = 32'h0000_0004;
      @(negedge clk);
      check_vec("abt_req", 32'(asic_req), 32'd0);
      ctrl = 32'd0;
      @(negedge clk);
      check_vec("abt_data_in", asic_data_in, 32'h0000_0055);
      repeat (4) @(negedge clk);

      // Reset during RELEASE
      ack_delay   = 2;
      model_rdata = 16'h2222;
      pulse_start(32'h0000_0101);
      wait_req(1'b1, 50, n);
      wait_req(1'b0, 50, n);
      check_vec("rel_reached", 32'(n < 50), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_vec("rel_rst_req", 32'(asic_req), 32'd0);
      check_vec("rel_rst_wdata", 32'(asic_wdata), 32'd0);
      check_vec("rel_rst_data_in", asic_data_in, 32'h0000_0000);
      rst = 1'b0;
      repeat (6) @(negedge clk);

      // Normal transaction afterwards
      asic_data_out = 32'hFFFF_A5A5;
      model_rdata   = 16'h1357;
      ack_delay     = 3;
      pulse_start(32'h0000_0301);
      check_vec("post_wdata", 32'(asic_wdata), 32'h0000_A5A5);
      wait_req(1'b1, 50, n);
      check_vec("post_req_latency", 32'(n), 32'd4);
      wait_done(100);
      check_vec("post_data_in", asic_data_in, 32'h4000_1357);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
